// File: rtl/button_valid_gen.sv
// Debounced push-button to valid/ready beat-burst generator with saturating beat counter and sticky full.
// Optional auto-repeat while the button is held: define BTN_AUTO_REPEAT_EN.
module button_valid_gen #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int BURST_LEN    = 1,
    parameter int DEPTH        = 255,
    parameter int CNT_W        = 8,
    parameter int REPEAT_CYC   = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic             ready,
    output logic             valid_out,
    output logic [CNT_W-1:0] valid_cnt,
    output logic             full,
    output logic             busy
);
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int BL_W = $clog2(BURST_LEN + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [BL_W-1:0]  BL_INIT  = BL_W'(BURST_LEN);
    localparam logic [BL_W-1:0]  BL_ONE   = BL_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic             btn_db_q, btn_db_d, btn_db_prev_q;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [BL_W-1:0]  beats_q, beats_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_evt;
    logic             press_evt;

    // Debounce: the level only follows sync2 after DEBOUNCE_CYC consecutive disagreeing cycles.
    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        if (sync2_q != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RP_W = $clog2(REPEAT_CYC + 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYC - 1);

    logic [RP_W-1:0] rep_q, rep_d;

    // Repeat timer only runs while idle with the button held, so it restarts after every burst.
    always_comb begin
        rep_d   = '0;
        rep_evt = 1'b0;
        if (state_q == IDLE && btn_db_q) begin
            if (rep_q == RP_LAST) begin
                rep_evt = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^REPEAT_CYC;
    assign rep_evt = 1'b0;
`endif

    assign press_evt = (btn_db_q & ~btn_db_prev_q) | rep_evt;

    always_comb begin
        state_d   = state_q;
        beats_d   = beats_q;
        cnt_d     = cnt_q;
        valid_out = 1'b0;
        busy      = 1'b0;
        full      = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_evt) begin
                    state_d = ISSUE;
                    beats_d = BL_INIT;
                end
            end
            ISSUE: begin
                valid_out = 1'b1;
                busy      = 1'b1;
                if (ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    beats_d = beats_q - 1'b1;
                    // Reaching DEPTH abandons whatever is left of the burst.
                    if (cnt_q == CNT_LAST) begin
                        state_d = FULL;
                        beats_d = '0;
                    end else if (beats_q == BL_ONE) begin
                        state_d = IDLE;
                    end
                end
            end
            FULL: begin
                full = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
            db_cnt_q      <= '0;
            state_q       <= IDLE;
            beats_q       <= '0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= button;
            sync2_q       <= sync1_q;
            btn_db_q      <= btn_db_d;
            btn_db_prev_q <= btn_db_q;
            db_cnt_q      <= db_cnt_d;
            state_q       <= state_d;
            beats_q       <= beats_d;
            cnt_q         <= cnt_d;
        end
    end

    assign valid_cnt = cnt_q;

endmodule

// File: tb/tb_button_valid_gen.sv
// Bench for button_valid_gen: directed scenarios plus random button/ready traffic against a cycle model.
module tb_button_valid_gen;
    localparam int DEBOUNCE_CYC = 4;
    localparam int BURST_LEN    = 3;
    localparam int DEPTH        = 7;
    localparam int CNT_W        = 8;
    localparam int REPEAT_CYC   = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             button = 1'b0;
    logic             ready = 1'b0;
    logic             valid_out, full, busy;
    logic [CNT_W-1:0] valid_cnt;

    int vectors = 0;
    int miscompares = 0;

    button_valid_gen #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .BURST_LEN   (BURST_LEN),
        .DEPTH       (DEPTH),
        .CNT_W       (CNT_W),
        .REPEAT_CYC  (REPEAT_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .button   (button),
        .ready    (ready),
        .valid_out(valid_out),
        .valid_cnt(valid_cnt),
        .full     (full),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    // Reference model: button delayed two cycles, debounced by a sliding window of the
    // last DEBOUNCE_CYC samples, and a count of outstanding beats in the current burst.
    bit m_s1, m_s2, m_db, m_db_prev, m_full;
    bit m_win [DEBOUNCE_CYC];
    int m_beats, m_cnt;
`ifdef BTN_AUTO_REPEAT_EN
    int m_rep;
`endif

    always @(posedge clk) begin : ref_model
        bit press, all_diff;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_db = 0; m_db_prev = 0; m_full = 0;
            m_beats = 0; m_cnt = 0;
            foreach (m_win[i]) m_win[i] = 0;
`ifdef BTN_AUTO_REPEAT_EN
            m_rep = 0;
`endif
        end else begin
            press = m_db && !m_db_prev;
`ifdef BTN_AUTO_REPEAT_EN
            if (!m_full && m_beats == 0 && m_db) begin
                if (m_rep == REPEAT_CYC - 1) begin
                    press = 1;
                    m_rep = 0;
                end else begin
                    m_rep++;
                end
            end else begin
                m_rep = 0;
            end
`endif
            if (!m_full) begin
                if (m_beats > 0) begin
                    if (ready) begin
                        m_cnt++;
                        m_beats--;
                        if (m_cnt == DEPTH) begin
                            m_full  = 1;
                            m_beats = 0;
                        end
                    end
                end else if (press) begin
                    m_beats = BURST_LEN;
                end
            end
            m_db_prev = m_db;
            for (int i = DEBOUNCE_CYC - 1; i > 0; i--) m_win[i] = m_win[i-1];
            m_win[0] = m_s2;
            all_diff = 1;
            foreach (m_win[i]) if (m_win[i] == m_db) all_diff = 0;
            if (all_diff) m_db = !m_db;
            m_s2 = m_s1;
            m_s1 = button;
        end
    end

    function automatic logic [CNT_W+2:0] model_vec();
        return {m_beats > 0, m_beats > 0, m_full, CNT_W'(m_cnt)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; button = 1'b0; ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid_out got %b expected 0", valid_out); end
        vectors++;
        if (valid_cnt !== '0) begin miscompares++; $display("FAIL reset_valid_cnt got %0d expected 0", valid_cnt); end
        vectors++;
        if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b expected 0", full); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b expected 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_no_press();
        int seen = 0;
        button = 1'b1; ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            vectors++;
            if ({valid_out, busy, full, valid_cnt} !== model_vec()) begin
                miscompares++;
                $display("FAIL no_press cycle %0d got %h expected %h", c, {valid_out, busy, full, valid_cnt}, model_vec());
            end
            if (valid_out === 1'b1) seen++;
            if (c == 2) button = 1'b0;
        end
        vectors++;
        if (seen != 0 || valid_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL no_press_glitch valid cycles %0d cnt %0d expected 0 and 0", seen, valid_cnt);
        end
    endtask

    task automatic test_burst();
        int nv = 0, first = -1, last = -1;
        ready = 1'b1; button = 1'b1;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            vectors++;
            if ({valid_out, busy, full, valid_cnt} !== model_vec()) begin
                miscompares++;
                $display("FAIL burst cycle %0d got %h expected %h", c, {valid_out, busy, full, valid_cnt}, model_vec());
            end
            if (valid_out === 1'b1) begin
                nv++;
                if (first < 0) first = c;
                last = c;
            end
            if (c == 9) button = 1'b0;
        end
        vectors++;
        if (nv != 3 || last - first + 1 != 3) begin
            miscompares++;
            $display("FAIL burst_shape valid cycles %0d span %0d expected 3 and 3", nv, last - first + 1);
        end
        vectors++;
        if (valid_cnt !== 8'd3) begin miscompares++; $display("FAIL burst_cnt got %0d expected 3", valid_cnt); end
    endtask

    task automatic test_stall();
        int vcyc = 0;
        ready = 1'b0; button = 1'b1;
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            vectors++;
            if ({valid_out, busy, full, valid_cnt} !== model_vec()) begin
                miscompares++;
                $display("FAIL stall cycle %0d got %h expected %h", c, {valid_out, busy, full, valid_cnt}, model_vec());
            end
            if (valid_out === 1'b1 && !ready) begin
                vcyc++;
                vectors++;
                if (valid_cnt !== 8'd3) begin miscompares++; $display("FAIL stall_hold_cnt got %0d expected 3", valid_cnt); end
            end
            if (c == 9) button = 1'b0;
            if (vcyc == 5) ready = 1'b1;
        end
        vectors++;
        if (vcyc != 5 || valid_cnt !== 8'd6) begin
            miscompares++;
            $display("FAIL stall_result held %0d cnt %0d expected 5 and 6", vcyc, valid_cnt);
        end
    endtask

    task automatic test_full();
        for (int p = 0; p < 2; p++) begin
            int nv = 0;
            ready = 1'b1; button = 1'b1;
            for (int c = 0; c < 26; c++) begin
                @(negedge clk);
                vectors++;
                if ({valid_out, busy, full, valid_cnt} !== model_vec()) begin
                    miscompares++;
                    $display("FAIL full cycle %0d press %0d got %h expected %h", c, p, {valid_out, busy, full, valid_cnt}, model_vec());
                end
                if (valid_out === 1'b1) nv++;
                if (c == 9) button = 1'b0;
            end
            vectors++;
            if (nv != (p == 0 ? 1 : 0) || valid_cnt !== 8'd7 || full !== 1'b1) begin
                miscompares++;
                $display("FAIL full_press%0d beats %0d cnt %0d full %b expected %0d 7 1", p, nv, valid_cnt, full, (p == 0 ? 1 : 0));
            end
        end
    endtask

    task automatic test_rst_mid();
        int nv = 0;
        bit hit = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; button = 1'b1; ready = 1'b1;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            vectors++;
            if ({valid_out, busy, full, valid_cnt} !== model_vec()) begin
                miscompares++;
                $display("FAIL rst_mid cycle %0d got %h expected %h", c, {valid_out, busy, full, valid_cnt}, model_vec());
            end
            if (valid_out === 1'b1) nv++;
            if (nv == 2) begin
                rst = 1'b1;
                button = 1'b0;
                hit = 1;
            end
        end
        vectors++;
        if (!hit) begin miscompares++; $display("FAIL rst_mid_timeout beats seen %0d expected 2", nv); end
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({valid_out, busy, full, valid_cnt} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_clear got %h expected 0", {valid_out, busy, full, valid_cnt});
        end
        button = 1'b1;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            vectors++;
            if ({valid_out, busy, full, valid_cnt} !== model_vec()) begin
                miscompares++;
                $display("FAIL rst_mid_fresh cycle %0d got %h expected %h", c, {valid_out, busy, full, valid_cnt}, model_vec());
            end
            if (c == 9) button = 1'b0;
        end
        vectors++;
        if (valid_cnt !== 8'd3) begin miscompares++; $display("FAIL rst_mid_fresh_cnt got %0d expected 3", valid_cnt); end
    endtask

`ifdef BTN_AUTO_REPEAT_EN
    task automatic test_repeat();
        int end_c = -1, start_c = -1;
        logic prev_v = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; ready = 1'b1; button = 1'b1;
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            vectors++;
            if ({valid_out, busy, full, valid_cnt} !== model_vec()) begin
                miscompares++;
                $display("FAIL repeat cycle %0d got %h expected %h", c, {valid_out, busy, full, valid_cnt}, model_vec());
            end
            if (prev_v && !valid_out && end_c < 0) end_c = c;
            if (!prev_v && valid_out === 1'b1 && end_c >= 0 && start_c < 0) start_c = c;
            prev_v = valid_out;
        end
        button = 1'b0;
        vectors++;
        if (end_c < 0 || start_c < 0 || start_c - end_c != REPEAT_CYC) begin
            miscompares++;
            $display("FAIL repeat_gap got %0d expected %0d", start_c - end_c, REPEAT_CYC);
        end
    endtask
`endif

    task automatic test_random();
        int hold = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            vectors++;
            if ({valid_out, busy, full, valid_cnt} !== model_vec()) begin
                miscompares++;
                $display("FAIL random cycle %0d got %h expected %h", c, {valid_out, busy, full, valid_cnt}, model_vec());
            end
            if (hold == 0) begin
                button = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 30);
            end else begin
                hold--;
            end
            ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0) || (m_full && $urandom_range(0, 9) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_no_press();
        test_burst();
        test_stall();
        test_full();
        test_rst_mid();
`ifdef BTN_AUTO_REPEAT_EN
        test_repeat();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
